// File: rtl/pong_pkg.sv
// Shared constants for the pong input path: channel indices and paddle direction codes.
package pong_pkg;

    localparam int unsigned CH_LEFT_BTN_1     = 0;
    localparam int unsigned CH_RIGHT_BTN_1    = 1;
    localparam int unsigned CH_LEFT_BTN_2     = 2;
    localparam int unsigned CH_RIGHT_BTN_2    = 3;
    localparam int unsigned CH_LEFT_JOYCON_1  = 4;
    localparam int unsigned CH_RIGHT_JOYCON_1 = 5;
    localparam int unsigned CH_LEFT_JOYCON_2  = 6;
    localparam int unsigned CH_RIGHT_JOYCON_2 = 7;

    typedef enum logic [1:0] {
        DIR_IDLE  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10
    } dir_e;

    // Conflicting left+right requests cancel out to idle.
    function automatic dir_e dir_encode(input logic left, input logic right);
        if (left && !right) begin
            return DIR_LEFT;
        end else if (right && !left) begin
            return DIR_RIGHT;
        end
        return DIR_IDLE;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single-channel debouncer: polarity fix, 2-flop synchroniser, stability counter,
// registered level and one-cycle press/release pulses.
module debounce_ch #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter logic        INVERT          = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Counter only runs while the synchronised input disagrees with the
    // accepted level; it is cleared on agreement and on the toggle itself.
    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == THRESH) begin
                level_d   = sync_q[1];
                press_d   = sync_q[1];
                release_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], i_raw ^ INVERT};
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces the player buttons/joycons and derives per-player paddle direction requests.
module input_debouncer
    import pong_pkg::*;
#(
    parameter int unsigned     N_CH            = 8,
    parameter int unsigned     DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned     CNT_W           = 20,
    parameter logic [N_CH-1:0] INVERT          = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_raw,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [1:0]      o_dir_p1,
    output logic [1:0]      o_dir_p2
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .INVERT          (INVERT[g])
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_raw     (i_raw[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g])
        );
    end

    // Button and joycon of the same side are interchangeable for each player.
    assign o_dir_p1 = dir_encode(o_level[CH_LEFT_BTN_1]  | o_level[CH_LEFT_JOYCON_1],
                                 o_level[CH_RIGHT_BTN_1] | o_level[CH_RIGHT_JOYCON_1]);
    assign o_dir_p2 = dir_encode(o_level[CH_LEFT_BTN_2]  | o_level[CH_LEFT_JOYCON_2],
                                 o_level[CH_RIGHT_BTN_2] | o_level[CH_RIGHT_JOYCON_2]);

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: one plain and one ch0-inverted instance share stimulus.
module tb_input_debouncer;

    localparam int unsigned D = 16;
    localparam logic [7:0] INV0 = 8'h00;
    localparam logic [7:0] INV1 = 8'h01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] raw = 8'h00;

    logic [7:0] lvl0, prs0, rel0, lvl1, prs1, rel1;
    logic [1:0] d1_0, d2_0, d1_1, d2_1;

    typedef struct packed {
        logic [7:0] l0; logic [7:0] p0; logic [7:0] r0; logic [1:0] a0; logic [1:0] b0;
        logic [7:0] l1; logic [7:0] p1; logic [7:0] r1; logic [1:0] a1; logic [1:0] b1;
    } obs_t;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    input_debouncer #(.N_CH(8), .DEBOUNCE_CYCLES(D), .CNT_W(8), .INVERT(INV0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_raw(raw),
        .o_level(lvl0), .o_press(prs0), .o_release(rel0), .o_dir_p1(d1_0), .o_dir_p2(d2_0));

    input_debouncer #(.N_CH(8), .DEBOUNCE_CYCLES(D), .CNT_W(8), .INVERT(INV1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_raw(raw),
        .o_level(lvl1), .o_press(prs1), .o_release(rel1), .o_dir_p1(d1_1), .o_dir_p2(d2_1));

    function automatic logic [1:0] dir_of(input logic l, input logic r);
        if (l && !r) return 2'b01;
        if (r && !l) return 2'b10;
        return 2'b00;
    endfunction

    // Reference model: a level flips once its pipelined input has disagreed
    // with it for D consecutive edges (timestamp of last agreement).
    int unsigned n = 0;
    logic [7:0]  m_lvl [2];
    int unsigned m_agree [2][8];
    logic [15:0] m_dly [$];
    obs_t        sb [$];

    always @(posedge clk) begin
        obs_t        e;
        logic [15:0] cmp;
        logic [7:0]  pr [2];
        logic [7:0]  rl [2];
        logic        c;
        e = '0;
        if (!rst_n) begin
            n = 0;
            m_dly = {16'h0000, 16'h0000};
            for (int d = 0; d < 2; d++) begin
                m_lvl[d] = 8'h00;
                for (int i = 0; i < 8; i++) m_agree[d][i] = 0;
            end
        end else begin
            n++;
            cmp = m_dly.pop_front();
            m_dly.push_back({raw ^ INV1, raw ^ INV0});
            for (int d = 0; d < 2; d++) begin
                pr[d] = 8'h00;
                rl[d] = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    c = cmp[d*8+i];
                    if (c == m_lvl[d][i]) begin
                        m_agree[d][i] = n;
                    end else if (n - m_agree[d][i] == D) begin
                        m_lvl[d][i] = c;
                        m_agree[d][i] = n;
                        if (c) pr[d][i] = 1'b1;
                        else   rl[d][i] = 1'b1;
                    end
                end
            end
            e.l0 = m_lvl[0]; e.p0 = pr[0]; e.r0 = rl[0];
            e.a0 = dir_of(m_lvl[0][0] | m_lvl[0][4], m_lvl[0][1] | m_lvl[0][5]);
            e.b0 = dir_of(m_lvl[0][2] | m_lvl[0][6], m_lvl[0][3] | m_lvl[0][7]);
            e.l1 = m_lvl[1]; e.p1 = pr[1]; e.r1 = rl[1];
            e.a1 = dir_of(m_lvl[1][0] | m_lvl[1][4], m_lvl[1][1] | m_lvl[1][5]);
            e.b1 = dir_of(m_lvl[1][2] | m_lvl[1][6], m_lvl[1][3] | m_lvl[1][7]);
        end
        sb.push_back(e);
    end

    // Monitor: every cycle the DUT pair presents a full output snapshot.
    always @(posedge clk) begin
        obs_t exp_o, act;
        #1;
        act = {lvl0, prs0, rel0, d1_0, d2_0, lvl1, prs1, rel1, d1_1, d2_1};
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %h required an expectation", act);
        end else begin
            exp_o = sb.pop_front();
            if (act !== exp_o) begin
                n_fail++;
                $display("FAIL cycle_%0d: got %h required %h", n, act, exp_o);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp_v);
        end
    endtask

    task automatic to_edge(input int unsigned k);
        int unsigned guard;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (n < k && guard < 500);
        if (n != k) begin
            n_cmp++;
            n_fail++;
            $display("FAIL to_edge: got edge %0d required %0d", n, k);
        end
    endtask

    initial begin
        int unsigned e;
        logic        saw;

        @(posedge clk);
        #2;
        chk("reset_level0", {24'h0, lvl0}, 32'h0);
        chk("reset_pulses0", {16'h0, prs0, rel0}, 32'h0);
        chk("reset_dir0", {28'h0, d1_0, d2_0}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single press on ch0 settled before edge 10.
        to_edge(9);
        @(negedge clk);
        raw[0] = 1'b1;
        to_edge(26);
        chk("ch0_level_e26", {31'h0, lvl0[0]}, 32'h0);
        to_edge(27);
        chk("ch0_level_e27", {31'h0, lvl0[0]}, 32'h1);
        chk("ch0_press_e27", {24'h0, prs0}, 32'h01);
        chk("dir_p1_left", {30'h0, d1_0}, 32'h1);
        to_edge(28);
        chk("ch0_press_once", {24'h0, prs0}, 32'h0);

        // Short glitch on ch1 is rejected, a long hold is accepted.
        @(negedge clk);
        raw[0] = 1'b0;
        raw[1] = 1'b1;
        repeat (10) @(negedge clk);
        raw[1] = 1'b0;
        saw = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            saw = saw | prs0[1] | lvl0[1];
        end
        chk("ch1_glitch_rejected", {31'h0, saw}, 32'h0);
        @(negedge clk);
        raw[1] = 1'b1;
        e = n + 1;
        to_edge(e + D);
        chk("ch1_before_thresh", {31'h0, lvl0[1]}, 32'h0);
        to_edge(e + D + 1);
        chk("ch1_accepted", {30'h0, prs0[1], lvl0[1]}, 32'h3);
        chk("dir_p1_right", {30'h0, d1_0}, 32'h2);
        @(negedge clk);
        raw[1] = 1'b0;
        repeat (D + 4) @(negedge clk);

        // Left and right joycons together cancel; dropping left leaves right.
        raw[5:4] = 2'b11;
        e = n + 1;
        to_edge(e + D + 1);
        chk("ch45_level", {30'h0, lvl0[5:4]}, 32'h3);
        chk("dir_p1_both_idle", {30'h0, d1_0}, 32'h0);
        @(negedge clk);
        raw[4] = 1'b0;
        e = n + 1;
        to_edge(e + D + 1);
        chk("ch4_release", {24'h0, rel0}, 32'h10);
        chk("dir_p1_right_after", {30'h0, d1_0}, 32'h2);
        to_edge(e + D + 2);
        chk("ch4_release_once", {24'h0, rel0}, 32'h0);

        // All channels at once.
        @(negedge clk);
        raw = 8'h00;
        repeat (D + 4) @(negedge clk);
        raw = 8'hFF;
        e = n + 1;
        to_edge(e + D + 1);
        chk("all_press", {24'h0, prs0}, 32'hFF);
        chk("all_dir", {28'h0, d1_0, d2_0}, 32'h0);
        chk("all_press_inv", {16'h0, prs1, rel1}, 32'hFE01);

        // Random chatter with one mid-run reset; scoreboard does the checking.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 11) == 0) raw[i] = ~raw[i];
            if (c == 200) rst_n = 1'b0;
            if (c == 202) rst_n = 1'b1;
        end

        // Inverted channel, reset mid-count, input held across reset release.
        @(negedge clk);
        raw = 8'h00;
        repeat (D + 4) @(negedge clk);
        chk("inv_level", {16'h0, lvl1, lvl0}, 32'h0100);
        raw = 8'h02;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_dut1", {8'h0, lvl1, prs1, rel1}, 32'h0);
        chk("rst_async_dut0", {8'h0, lvl0, prs0, rel0}, 32'h0);
        chk("rst_async_dir", {24'h0, d1_0, d2_0, d1_1, d2_1}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        to_edge(D + 1);
        chk("inv_press_early", {31'h0, prs1[0]}, 32'h0);
        to_edge(D + 2);
        chk("inv_press_d2", {24'h0, prs1}, 32'h03);
        chk("held_press_dut0", {24'h0, prs0}, 32'h02);
        to_edge(D + 3);
        chk("inv_press_once", {31'h0, prs1[0]}, 32'h0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
